// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
package boot_pkg;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        DATA  = 3'd1,
        CSUM  = 3'd2,
        RUN   = 3'd3,
        ERROR = 3'd4
    } boot_state_e;

    localparam int         HDR_BYTES = 4;
    localparam logic [7:0] CSUM_INIT = 8'h00;
    // Byte counter value that completes a 32-bit word (header or payload)
    localparam logic [1:0] LAST_BYTE = 2'(HDR_BYTES - 1);

    // True while the loader is still consuming the frame
    function automatic logic is_loading(input boot_state_e st);
        logic busy;
        case (st)
            HDR, DATA, CSUM: busy = 1'b1;
            default:         busy = 1'b0;
        endcase
        return busy;
    endfunction

endpackage

// File: rtl/uart_byte_reader.sv
// Pops one byte at a time from the RX FIFO and hands it to the loader FSM.
// A pop in cycle t presents the byte on byte_valid/byte_data in cycle t+1.
module uart_byte_reader (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       uart_empty,
    input  logic [7:0] uart_in,
    output logic       uart_rdreq,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    logic pending_r;

    // Never pop while a byte is still in flight, so at most one byte per 2 cycles
    assign uart_rdreq = enable && !uart_empty && !pending_r;
    // The FIFO drives the popped byte one cycle after the pop
    assign byte_valid = pending_r;
    assign byte_data  = uart_in;

    // Track the outstanding pop; the byte is consumed in the cycle it lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= 1'b0;
        end else begin
            pending_r <= uart_rdreq;
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Boot loader: holds the CPU, loads a framed little-endian image from the
// UART RX FIFO into memory, verifies its XOR checksum, then releases the CPU.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_empty,
    input  logic [7:0]  uart_in,
    output logic        uart_rdreq,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_run,
    output logic        load_busy,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    localparam logic [31:0] MAX_WORDS_C = 32'(MAX_WORDS);

    boot_state_e state_r, state_nxt_s;
    logic [1:0]  byte_cnt_r, byte_cnt_nxt_s;
    logic [31:0] word_r, word_nxt_s;
    logic [31:0] count_r, count_nxt_s;
    logic [15:0] idx_r, idx_nxt_s;
    logic [7:0]  csum_r, csum_nxt_s;
    logic [15:0] words_loaded_r, words_loaded_nxt_s;
    logic        mem_we_r, mem_we_nxt_s;
    logic [31:0] mem_addr_r, mem_addr_nxt_s;
    logic [31:0] mem_wdata_r, mem_wdata_nxt_s;
    logic        cpu_run_r, cpu_run_nxt_s;
    logic        load_error_r, load_error_nxt_s;
    logic        load_busy_r;

    logic        byte_valid_s;
    logic [7:0]  byte_data_s;
    logic [31:0] word_full_s;
    logic        word_done_s;

    uart_byte_reader u_reader (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (load_busy_r),
        .uart_empty (uart_empty),
        .uart_in    (uart_in),
        .uart_rdreq (uart_rdreq),
        .byte_valid (byte_valid_s),
        .byte_data  (byte_data_s)
    );

    // Word as it stands once the incoming byte is shifted in (little-endian)
    assign word_full_s = {byte_data_s, word_r[31:8]};
    assign word_done_s = byte_valid_s && (byte_cnt_r == LAST_BYTE);

    // Next-state and next-output logic for the load sequencer
    always_comb begin
        state_nxt_s        = state_r;
        byte_cnt_nxt_s     = byte_cnt_r;
        word_nxt_s         = word_r;
        count_nxt_s        = count_r;
        idx_nxt_s          = idx_r;
        csum_nxt_s         = csum_r;
        words_loaded_nxt_s = words_loaded_r;
        mem_we_nxt_s       = 1'b0;
        mem_addr_nxt_s     = mem_addr_r;
        mem_wdata_nxt_s    = mem_wdata_r;
        cpu_run_nxt_s      = cpu_run_r;
        load_error_nxt_s   = load_error_r;

        if (byte_valid_s) begin
            byte_cnt_nxt_s = byte_cnt_r + 2'd1;
            word_nxt_s     = word_full_s;
        end else begin
            byte_cnt_nxt_s = byte_cnt_r;
        end

        case (state_r)
            HDR: begin
                if (word_done_s) begin
                    count_nxt_s = word_full_s;
                    if (word_full_s == 32'd0) begin
                        state_nxt_s = CSUM;
                    end else if (word_full_s > MAX_WORDS_C) begin
                        state_nxt_s      = ERROR;
                        load_error_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    state_nxt_s = HDR;
                end
            end
            DATA: begin
                if (byte_valid_s) begin
                    csum_nxt_s = csum_r ^ byte_data_s;
                end else begin
                    csum_nxt_s = csum_r;
                end
                if (word_done_s) begin
                    mem_we_nxt_s       = 1'b1;
                    mem_addr_nxt_s     = BASE_ADDR + {14'h0000, idx_r, 2'b00};
                    mem_wdata_nxt_s    = word_full_s;
                    idx_nxt_s          = idx_r + 16'd1;
                    words_loaded_nxt_s = words_loaded_r + 16'd1;
                    if (({16'h0000, idx_r} + 32'd1) == count_r) begin
                        state_nxt_s = CSUM;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    state_nxt_s = DATA;
                end
            end
            CSUM: begin
                if (byte_valid_s) begin
                    if (byte_data_s == csum_r) begin
                        state_nxt_s   = RUN;
                        cpu_run_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s      = ERROR;
                        load_error_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = CSUM;
                end
            end
            RUN: begin
                state_nxt_s = RUN;
            end
            ERROR: begin
                state_nxt_s = ERROR;
            end
            default: begin
                state_nxt_s      = ERROR;
                load_error_nxt_s = 1'b1;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= HDR;
            byte_cnt_r     <= 2'd0;
            word_r         <= 32'h0000_0000;
            count_r        <= 32'h0000_0000;
            idx_r          <= 16'h0000;
            csum_r         <= CSUM_INIT;
            words_loaded_r <= 16'h0000;
            mem_we_r       <= 1'b0;
            mem_addr_r     <= 32'h0000_0000;
            mem_wdata_r    <= 32'h0000_0000;
            cpu_run_r      <= 1'b0;
            load_error_r   <= 1'b0;
            load_busy_r    <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            byte_cnt_r     <= byte_cnt_nxt_s;
            word_r         <= word_nxt_s;
            count_r        <= count_nxt_s;
            idx_r          <= idx_nxt_s;
            csum_r         <= csum_nxt_s;
            words_loaded_r <= words_loaded_nxt_s;
            mem_we_r       <= mem_we_nxt_s;
            mem_addr_r     <= mem_addr_nxt_s;
            mem_wdata_r    <= mem_wdata_nxt_s;
            cpu_run_r      <= cpu_run_nxt_s;
            load_error_r   <= load_error_nxt_s;
            // Busy drops on the same edge as the terminal state is entered,
            // so no pop is issued in RUN or ERROR
            load_busy_r    <= is_loading(state_nxt_s);
        end
    end

    assign mem_we       = mem_we_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign cpu_run      = cpu_run_r;
    assign load_busy    = load_busy_r;
    assign load_error   = load_error_r;
    assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: a FIFO model feeds image bytes,
// expected memory writes are queued up front and a monitor checks each write.
module tb_uart_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_empty;
    logic [7:0]  uart_in;
    logic        uart_rdreq;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_run;
    logic        load_busy;
    logic        load_error;
    logic [15:0] words_loaded;

    uart_boot_loader #(
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .uart_empty   (uart_empty),
        .uart_in      (uart_in),
        .uart_rdreq   (uart_rdreq),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_run      (cpu_run),
        .load_busy    (load_busy),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] wl;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc_cnt = 0;
    int          last_cap_cyc = -1;
    int          gap_cycles = 0;
    int          gap_cnt = 0;
    logic [7:0]  tx_q[$];
    wr_t         exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        tx_q.push_back(b);
    endtask

    task automatic push_word(input logic [31:0] w);
        tx_q.push_back(w[7:0]);
        tx_q.push_back(w[15:8]);
        tx_q.push_back(w[23:16]);
        tx_q.push_back(w[31:24]);
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d, input logic [15:0] wl);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.wl   = wl;
        exp_q.push_back(e);
    endtask

    // Cycle counter, advanced on every active edge
    initial begin
        forever begin
            @(posedge clk);
            cyc_cnt++;
        end
    end

    // RX FIFO model: empty when no data or during a starvation gap; a popped
    // byte appears on uart_in for the following cycle
    initial begin
        logic [7:0] b;
        uart_empty = 1'b1;
        uart_in    = 8'h00;
        forever begin
            @(negedge clk);
            if (gap_cnt > 0) begin
                gap_cnt--;
                uart_empty = 1'b1;
            end else begin
                uart_empty = (tx_q.size() == 0);
            end
            #1;
            if (uart_rdreq) begin
                chk("rdreq_while_empty", {63'd0, uart_empty}, 64'd0);
                if (!uart_empty) begin
                    b = tx_q.pop_front();
                    @(posedge clk);
                    #1;
                    uart_in = b;
                    gap_cnt = gap_cycles;
                    if (tx_q.size() == 0) begin
                        last_cap_cyc = cyc_cnt + 1;
                    end
                end
            end
        end
    end

    // Write monitor: every mem_we pulse must match the next queued write
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {32'd0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", {32'd0, mem_addr}, {32'd0, e.addr});
                    chk("wr_data", {32'd0, mem_wdata}, {32'd0, e.data});
                    chk("wr_words_loaded", {48'd0, words_loaded}, {48'd0, e.wl});
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        tx_q.delete();
        exp_q.delete();
        gap_cycles = 0;
        gap_cnt = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {uart_rdreq, mem_we, cpu_run, load_busy, load_error, words_loaded},
            64'd0);
        chk("reset_mem_bus", {mem_addr, mem_wdata}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_result(input string name, input logic exp_run, input logic [15:0] exp_words);
        int n;
        n = 0;
        while (!(cpu_run || load_error) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            chk({name, "_timeout"}, 64'd1, 64'd0);
        end else begin
            chk({name, "_done_cycle"}, 64'(cyc_cnt), 64'(last_cap_cyc));
        end
        chk({name, "_cpu_run"}, {63'd0, cpu_run}, {63'd0, exp_run});
        chk({name, "_load_error"}, {63'd0, load_error}, {63'd0, ~exp_run});
        chk({name, "_words"}, {48'd0, words_loaded}, {48'd0, exp_words});
        chk({name, "_busy"}, {63'd0, load_busy}, 64'd0);
        chk({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
        // Terminal state: further FIFO data must be left untouched
        push_byte(8'hAA);
        push_byte(8'h55);
        push_byte(8'h0F);
        repeat (20) @(negedge clk);
        chk({name, "_no_more_reads"}, 64'(tx_q.size()), 64'd3);
        chk({name, "_flags_hold"}, {62'd0, cpu_run, load_error}, {62'd0, exp_run, ~exp_run});
    endtask

    task automatic push_nominal();
        push_word(32'd2);
        push_word(32'h0010_0513);
        push_word(32'h0020_0593);
    endtask

    initial begin
        int n;

        // Nominal two-word load
        do_reset();
        exp_wr(32'h0, 32'h0010_0513, 16'd1);
        exp_wr(32'h4, 32'h0020_0593, 16'd2);
        push_nominal();
        push_byte(8'hB0);
        wait_result("nominal", 1'b1, 16'd2);

        // Empty image
        do_reset();
        push_word(32'd0);
        push_byte(8'h00);
        wait_result("empty", 1'b1, 16'd0);

        // Bad checksum
        do_reset();
        exp_wr(32'h0, 32'h0010_0513, 16'd1);
        exp_wr(32'h4, 32'h0020_0593, 16'd2);
        push_nominal();
        push_byte(8'hB1);
        wait_result("bad_csum", 1'b0, 16'd2);

        // Oversize count (MAX_WORDS = 4)
        do_reset();
        push_word(32'd5);
        wait_result("oversize", 1'b0, 16'd0);

        // Count exactly MAX_WORDS is accepted
        do_reset();
        exp_wr(32'h0, 32'h1122_3344, 16'd1);
        exp_wr(32'h4, 32'hAABB_CCDD, 16'd2);
        exp_wr(32'h8, 32'h0102_0304, 16'd3);
        exp_wr(32'hC, 32'hF0E0_D0C0, 16'd4);
        push_word(32'd4);
        push_word(32'h1122_3344);
        push_word(32'hAABB_CCDD);
        push_word(32'h0102_0304);
        push_word(32'hF0E0_D0C0);
        push_byte(8'h40);
        wait_result("max_words", 1'b1, 16'd4);

        // FIFO starvation between every byte
        do_reset();
        gap_cycles = 10;
        exp_wr(32'h0, 32'h0010_0513, 16'd1);
        exp_wr(32'h4, 32'h0020_0593, 16'd2);
        push_nominal();
        push_byte(8'hB0);
        wait_result("starved", 1'b1, 16'd2);

        // Reset after the first data word, then full reload
        do_reset();
        exp_wr(32'h0, 32'h0010_0513, 16'd1);
        exp_wr(32'h4, 32'h0020_0593, 16'd2);
        push_nominal();
        push_byte(8'hB0);
        n = 0;
        while (exp_q.size() != 1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("midload_first_write_seen", 64'(exp_q.size()), 64'd1);
        do_reset();
        exp_wr(32'h0, 32'h0010_0513, 16'd1);
        exp_wr(32'h4, 32'h0020_0593, 16'd2);
        push_nominal();
        push_byte(8'hB0);
        wait_result("reload", 1'b1, 16'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
